// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared phase types and quadrature transition classifier
package encoder_pkg;

    typedef logic [1:0] phase_t;

    // Phase is packed as {a, b}; clockwise order is 00 -> 10 -> 11 -> 01 -> 00.
    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_10 = 2'b10;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_01 = 2'b01;

    typedef enum logic [1:0] {
        QTR_NONE    = 2'd0,
        QTR_INC     = 2'd1,
        QTR_DEC     = 2'd2,
        QTR_ILLEGAL = 2'd3
    } quarter_t;

    function automatic phase_t cw_next(input phase_t p);
        phase_t n;
        case (p)
            PH_00:   n = PH_10;
            PH_10:   n = PH_11;
            PH_11:   n = PH_01;
            default: n = PH_00;
        endcase
        return n;
    endfunction

    // Both bits flipping at once means a transition was missed.
    function automatic quarter_t classify(input phase_t prev, input phase_t cur);
        quarter_t q;
        if (prev == cur)
            q = QTR_NONE;
        else if ((prev ^ cur) == 2'b11)
            q = QTR_ILLEGAL;
        else if (cw_next(prev) == cur)
            q = QTR_INC;
        else
            q = QTR_DEC;
        return q;
    endfunction

endpackage

// File: rtl/debouncer.sv
// rtl/debouncer.sv - two-flop synchroniser plus stability counter for one pin
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Reset to 1 matches the idle pull-up level so release produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - debounced quadrature decode to step/dir/err pulses
module quadrature_decoder
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int DETENT_DIV      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic step,
    output logic dir,
    output logic err
);

    localparam int ACC_W = $clog2(DETENT_DIV) + 2;
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] DIV_POS = ACC_W'(DETENT_DIV);
    localparam logic signed [ACC_W-1:0] DIV_NEG = -DIV_POS;

    logic                    deb_a;
    logic                    deb_b;
    phase_t                  cur_phase;
    phase_t                  prev_phase;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_inc;
    logic signed [ACC_W-1:0] acc_dec;
    quarter_t                qtr;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (a),
        .stable (deb_a)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (b),
        .stable (deb_b)
    );

    assign qtr     = classify(prev_phase, cur_phase);
    assign acc_inc = acc + ONE;
    assign acc_dec = acc - ONE;

    // Register the debounced phase, classify against the previous one and
    // fold quarter-steps into whole detents; step and err are single-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_phase  <= PH_11;
            prev_phase <= PH_11;
            acc        <= '0;
            step       <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
        end else begin
            cur_phase  <= {deb_a, deb_b};
            prev_phase <= cur_phase;
            step       <= 1'b0;
            err        <= 1'b0;
            case (qtr)
                QTR_INC: begin
                    if (acc_inc == DIV_POS) begin
                        step <= 1'b1;
                        dir  <= 1'b1;
                        acc  <= '0;
                    end else begin
                        acc <= acc_inc;
                    end
                end
                QTR_DEC: begin
                    if (acc_dec == DIV_NEG) begin
                        step <= 1'b1;
                        dir  <= 1'b0;
                        acc  <= '0;
                    end else begin
                        acc <= acc_dec;
                    end
                end
                QTR_ILLEGAL: begin
                    err <= 1'b1;
                    acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// tb/tb_quadrature_decoder.sv - scoreboard bench for quadrature_decoder
module tb_quadrature_decoder;
    import encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a = 1'b1;
    logic b = 1'b1;
    logic step;
    logic dir;
    logic err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic saw_low;

    typedef struct {
        bit is_err;
        bit dir;
        int cyc;
    } ev_t;

    ev_t exp_q[$];

    quadrature_decoder #(.DEBOUNCE_CYCLES(4), .DETENT_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .step  (step),
        .dir   (dir),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive a phase, optionally register the event it must cause (kind 1 = step,
    // 2 = err), then hold. Capture is at the next posedge; output appears 7 edges later.
    task automatic drive(input phase_t ph, input int kind, input bit d);
        ev_t e;
        @(negedge clk);
        {a, b} = ph;
        if (kind != 0) begin
            e.is_err = (kind == 2);
            e.dir    = d;
            e.cyc    = cyc + 8;
            exp_q.push_back(e);
        end
        repeat (19) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n === 1'b1 && (step !== 1'b0 || err !== 1'b0)) begin
            check("step_err_exclusive", 32'(step & err), 0);
            check("event_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("event_is_err", 32'(err), 32'(e.is_err));
                check("event_is_step", 32'(step), 32'(!e.is_err));
                check("event_cycle", cyc, e.cyc);
                if (!e.is_err) check("event_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_step", 32'(step), 0);
        check("reset_dir", 32'(dir), 0);
        check("reset_err", 32'(err), 0);
        rst_n = 1'b1;

        // Idle with a reset pulse in the middle
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({step, dir, err}), 0);
            if (i == 100) begin
                #2 rst_n = 1'b0;
                #1 check("idle_async_reset", 32'({step, dir, err}), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        // Clockwise detent
        drive(PH_01, 0, 1'b0);
        drive(PH_00, 0, 1'b0);
        drive(PH_10, 0, 1'b0);
        drive(PH_11, 1, 1'b1);
        check("cw_dir_held", 32'(dir), 1);

        // Counter-clockwise detent, then dir must hold at 0
        drive(PH_10, 0, 1'b0);
        drive(PH_00, 0, 1'b0);
        drive(PH_01, 0, 1'b0);
        drive(PH_11, 1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("ccw_dir_held", 32'(dir), 0);
        end

        // Bounce rejection: 3-cycle low pulses on a
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            a = 1'b0;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("bounce_deb_a", 32'(dut.u_deb_a.stable), 1);
            end
            a = 1'b1;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                check("bounce_deb_a", 32'(dut.u_deb_a.stable), 1);
            end
        end
        // A 4-cycle low pulse is accepted
        @(negedge clk);
        a = 1'b0;
        saw_low = 1'b0;
        repeat (4) @(negedge clk);
        a = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (dut.u_deb_a.stable === 1'b0) saw_low = 1'b1;
        end
        check("pulse4_accepted", 32'(saw_low), 1);
        repeat (20) @(negedge clk);

        // Illegal transition, then a full clockwise detent from the reset accumulator
        drive(PH_00, 2, 1'b0);
        drive(PH_10, 0, 1'b0);
        drive(PH_11, 0, 1'b0);
        drive(PH_01, 0, 1'b0);
        drive(PH_00, 1, 1'b1);

        // Reversal cancels within a detent
        drive(PH_10, 0, 1'b0);
        drive(PH_11, 0, 1'b0);
        drive(PH_10, 0, 1'b0);
        drive(PH_00, 0, 1'b0);
        // Partial detent discarded by reset
        drive(PH_10, 0, 1'b0);
        drive(PH_11, 0, 1'b0);
        drive(PH_01, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async_dir", 32'(dir), 0);
        check("rst_async_step_err", 32'({step, err}), 0);
        a = 1'b1;
        b = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        drive(PH_01, 0, 1'b0);
        drive(PH_00, 0, 1'b0);
        drive(PH_10, 0, 1'b0);
        drive(PH_11, 1, 1'b1);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_dir", 32'(dir), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
